// File: rtl/rv_csr_arbiter.sv
// rv_csr_arbiter: shares one CSR file port between the core pipeline and the
// debug module. Each granted request runs as an atomic
// read / capture / optional write / respond sequence. The set and clear
// arithmetic and the read-only protection are resolved here.
module rv_csr_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // core port
  input  logic        i_core_req,
  input  logic [11:0] i_core_idx,
  input  logic [1:0]  i_core_op,
  input  logic [31:0] i_core_wdata,
  output logic        o_core_gnt,
  output logic        o_core_rvalid,
  output logic [31:0] o_core_rdata,
  output logic        o_core_err,
  // debug port
  input  logic        i_dbg_req,
  input  logic [11:0] i_dbg_idx,
  input  logic [1:0]  i_dbg_op,
  input  logic [31:0] i_dbg_wdata,
  output logic        o_dbg_gnt,
  output logic        o_dbg_rvalid,
  output logic [31:0] o_dbg_rdata,
  output logic        o_dbg_err,
  // CSR file port
  output logic        o_csr_re,
  output logic        o_csr_we,
  output logic [11:0] o_csr_idx,
  output logic [31:0] o_csr_wdata,
  input  logic [31:0] i_csr_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_READ  = 2'b00;
  localparam logic [OP_W-1:0] OP_SET   = 2'b10;
  localparam logic [OP_W-1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_RESP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   starve_q;
  logic [OP_W-1:0]    op_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               owner_dbg_q;

  logic               core_win;
  logic               dbg_win;
  logic               read_only;
  logic               skip_write;
  logic [DATA_W-1:0]  rmw_data;

  // Arbitration: debug first, core once debug has starved it STARVE_LIMIT times
  always_comb begin
    core_win = 1'b0;
    dbg_win  = 1'b0;
    if (state == S_IDLE) begin
      if (i_core_req && (!i_dbg_req || (starve_q == CNT_W'(STARVE_LIMIT)))) begin
        core_win = 1'b1;
      end else if (i_dbg_req) begin
        dbg_win = 1'b1;
      end
    end
  end

  assign o_core_gnt = core_win;
  assign o_dbg_gnt  = dbg_win;

  // Read-only decode on the latched address; read ops and protected writes skip WRITE
  assign read_only  = (o_csr_idx[11:10] == 2'b11);
  assign skip_write = (op_q == OP_READ) || read_only;

  // New CSR value computed from the data arriving this cycle
  always_comb begin
    rmw_data = wdata_q;
    case (op_q)
      OP_SET:   rmw_data = i_csr_rdata | wdata_q;
      OP_CLEAR: rmw_data = i_csr_rdata & ~wdata_q;
      default:  rmw_data = wdata_q;
    endcase
  end

  // Transaction sequencer with registered strobes and responses
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= S_IDLE;
      starve_q      <= '0;
      op_q          <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      owner_dbg_q   <= 1'b0;
      o_core_rvalid <= 1'b0;
      o_core_rdata  <= '0;
      o_core_err    <= 1'b0;
      o_dbg_rvalid  <= 1'b0;
      o_dbg_rdata   <= '0;
      o_dbg_err     <= 1'b0;
      o_csr_re      <= 1'b0;
      o_csr_we      <= 1'b0;
      o_csr_idx     <= '0;
      o_csr_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_win) begin
            starve_q    <= '0;
          end else if (!i_core_req) begin
            starve_q    <= '0;
          end else if (dbg_win) begin
            starve_q    <= starve_q + CNT_W'(1);
          end
          if (core_win || dbg_win) begin
            owner_dbg_q <= dbg_win;
            op_q        <= dbg_win ? i_dbg_op : i_core_op;
            wdata_q     <= dbg_win ? i_dbg_wdata : i_core_wdata;
            o_csr_idx   <= dbg_win ? i_dbg_idx : i_core_idx;
            o_csr_re    <= 1'b1;
            state       <= S_READ;
          end
        end
        S_READ: begin
          o_csr_re <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          rdata_q <= i_csr_rdata;
          if (skip_write) begin
            if (owner_dbg_q) begin
              o_dbg_rvalid  <= 1'b1;
              o_dbg_rdata   <= i_csr_rdata;
              o_dbg_err     <= (op_q != OP_READ);
            end else begin
              o_core_rvalid <= 1'b1;
              o_core_rdata  <= i_csr_rdata;
              o_core_err    <= (op_q != OP_READ);
            end
            state <= S_RESP;
          end else begin
            o_csr_we    <= 1'b1;
            o_csr_wdata <= rmw_data;
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          o_csr_we    <= 1'b0;
          o_csr_wdata <= '0;
          if (owner_dbg_q) begin
            o_dbg_rvalid  <= 1'b1;
            o_dbg_rdata   <= rdata_q;
            o_dbg_err     <= 1'b0;
          end else begin
            o_core_rvalid <= 1'b1;
            o_core_rdata  <= rdata_q;
            o_core_err    <= 1'b0;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          o_core_rvalid <= 1'b0;
          o_core_rdata  <= '0;
          o_core_err    <= 1'b0;
          o_dbg_rvalid  <= 1'b0;
          o_dbg_rdata   <= '0;
          o_dbg_err     <= 1'b0;
          o_csr_idx     <= '0;
          state         <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
